// File: rtl/numbers_arith_pkg.sv
// rtl/numbers_arith_pkg.sv - shared FSM state type and ovf bit positions for numbers_arith_seq
package numbers_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int OVF_W    = 5;
    localparam int OVF_SUM  = 4;
    localparam int OVF_DIFF = 3;
    localparam int OVF_PROD = 2;
    localparam int OVF_QUOT = 1;
    localparam int OVF_REM  = 0;

endpackage

// File: rtl/numbers_arith_divider.sv
// rtl/numbers_arith_divider.sv - restoring divider, one quotient bit per cycle, A_W cycles after start
module numbers_arith_divider #(
    parameter int A_W = 8,
    parameter int B_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [A_W-1:0] dividend,
    input  logic [B_W-1:0] divisor,
    output logic [A_W-1:0] quot,
    output logic [B_W-1:0] rem,
    output logic           done
);

    localparam int CW = $clog2(A_W + 1);

    // q_q starts as the dividend and is shifted out MSB-first while quotient bits shift in
    logic [A_W-1:0] q_q;
    logic [B_W-1:0] r_q;
    logic [B_W-1:0] d_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;

    logic [B_W:0]   shifted;
    logic [B_W-1:0] trial;
    logic           fits;

    // One restoring step: bring down the next dividend bit and try to subtract the divisor
    always_comb begin
        shifted = {r_q, q_q[A_W-1]};
        trial   = shifted[B_W-1:0] - d_q;
        fits    = (shifted >= {1'b0, d_q});
    end

    // Iteration state; done stays high until the next start so the caller can sample it freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            r_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            q_q    <= dividend;
            r_q    <= '0;
            d_q    <= divisor;
            cnt_q  <= CW'(A_W);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            q_q   <= {q_q[A_W-2:0], fits};
            r_q   <= fits ? trial : shifted[B_W-1:0];
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign quot = q_q;
    assign rem  = r_q;
    assign done = done_q;

endmodule

// File: rtl/numbers_arith_seq.sv
// rtl/numbers_arith_seq.sv - sequential add/sub/mul/div unit, fixed latency; NUMBERS_ARITH_OVF_EN adds ovf output
module numbers_arith_seq
    import numbers_arith_pkg::*;
#(
    parameter int A_W = 8,
    parameter int B_W = 5,
    parameter int R_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [R_W-1:0] sum_ab,
    output logic [R_W-1:0] diff_ab,
    output logic [R_W-1:0] prod_ab,
    output logic [R_W-1:0] quot_ab,
    output logic [R_W-1:0] rem_ab,
    output logic           div0
`ifdef NUMBERS_ARITH_OVF_EN
    ,
    output logic [OVF_W-1:0] ovf
`endif
);

    localparam int MW = A_W + B_W;
    localparam int XW = (MW > R_W) ? MW : R_W;
    localparam int CW = $clog2(B_W + 1);

    state_e         state_q, state_d;
    logic [A_W-1:0] a_q;
    logic [B_W-1:0] b_q;
    logic [MW-1:0]  acc_q;
    logic [CW-1:0]  cnt_q;
    logic [R_W-1:0] sum_q, diff_q, prod_q, quot_q, rem_q;
    logic           div0_q;

    logic           div_start;
    logic           div_done;
    logic [A_W-1:0] div_quot;
    logic [B_W-1:0] div_rem;

    // Next-state and handshake decode; the divider is kicked on the last multiply cycle
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = MUL;
            end
            MUL: begin
                if (cnt_q == CW'(B_W - 1)) begin
                    div_start = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (div_done) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand capture and shift-add multiply, one multiplier bit per MUL cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == IDLE && in_valid) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == MUL) begin
            cnt_q <= cnt_q + 1'b1;
            if (b_q[cnt_q]) acc_q <= acc_q + (MW'(a_q) << cnt_q);
        end
    end

    numbers_arith_divider #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (a_q),
        .divisor  (b_q),
        .quot     (div_quot),
        .rem      (div_rem),
        .done     (div_done)
    );

    // Result registers load once when the divide finishes and hold through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            diff_q <= '0;
            prod_q <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            div0_q <= 1'b0;
        end else if (state_q == DIV && div_done) begin
            sum_q  <= R_W'(XW'(a_q) + XW'(b_q));
            diff_q <= R_W'(XW'(a_q) - XW'(b_q));
            prod_q <= R_W'(XW'(acc_q));
            // A zero divisor still runs the full divide so latency stays fixed; its results are overridden
            quot_q <= (b_q == '0) ? '1 : R_W'(XW'(div_quot));
            rem_q  <= (b_q == '0) ? R_W'(XW'(a_q)) : R_W'(XW'(div_rem));
            div0_q <= (b_q == '0);
        end
    end

`ifdef NUMBERS_ARITH_OVF_EN
    logic [OVF_W-1:0] ovf_q;

    // Flag each result whose full-precision value does not fit in R_W unsigned bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else if (state_q == DIV && div_done) begin
            ovf_q[OVF_SUM]  <= ((XW'(a_q) + XW'(b_q)) >> R_W) != '0;
            ovf_q[OVF_DIFF] <= (a_q < b_q) || (((XW'(a_q) - XW'(b_q)) >> R_W) != '0);
            ovf_q[OVF_PROD] <= (XW'(acc_q) >> R_W) != '0;
            ovf_q[OVF_QUOT] <= (XW'(div_quot) >> R_W) != '0;
            ovf_q[OVF_REM]  <= (b_q == '0) ? ((XW'(a_q) >> R_W) != '0)
                                           : ((XW'(div_rem) >> R_W) != '0);
        end
    end

    assign ovf = ovf_q;
`endif

    assign sum_ab  = sum_q;
    assign diff_ab = diff_q;
    assign prod_ab = prod_q;
    assign quot_ab = quot_q;
    assign rem_ab  = rem_q;
    assign div0    = div0_q;

endmodule

// File: tb/tb_numbers_arith_seq.sv
// tb/tb_numbers_arith_seq.sv - directed scoreboard bench for numbers_arith_seq at default widths
module tb_numbers_arith_seq;

    localparam int A_W = 8;
    localparam int B_W = 5;
    localparam int R_W = 5;
    localparam int LAT = B_W + A_W + 1;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [R_W-1:0] sum_ab, diff_ab, prod_ab, quot_ab, rem_ab;
    logic           div0;
`ifdef NUMBERS_ARITH_OVF_EN
    logic [4:0]     ovf;
`endif

    typedef struct packed {
        logic [R_W-1:0] sum;
        logic [R_W-1:0] diff;
        logic [R_W-1:0] prod;
        logic [R_W-1:0] quot;
        logic [R_W-1:0] rem;
        logic           dz;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks   = 0;
    int   failures = 0;

    numbers_arith_seq #(
        .A_W (A_W),
        .B_W (B_W),
        .R_W (R_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_ab    (sum_ab),
        .diff_ab   (diff_ab),
        .prod_ab   (prod_ab),
        .quot_ab   (quot_ab),
        .rem_ab    (rem_ab),
        .div0      (div0)
`ifdef NUMBERS_ARITH_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input int av, input int bv);
        exp_t e;
        int   m = (1 << R_W) - 1;
        e.sum  = R_W'((av + bv) & m);
        e.diff = R_W'((av - bv) & m);
        e.prod = R_W'((av * bv) & m);
        if (bv == 0) begin
            e.quot = R_W'(m);
            e.rem  = R_W'(av & m);
            e.dz   = 1'b1;
        end else begin
            e.quot = R_W'((av / bv) & m);
            e.rem  = R_W'((av % bv) & m);
            e.dz   = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input exp_t e);
        check({tag, "_sum"},  32'(sum_ab),  32'(e.sum));
        check({tag, "_diff"}, 32'(diff_ab), 32'(e.diff));
        check({tag, "_prod"}, 32'(prod_ab), 32'(e.prod));
        check({tag, "_quot"}, 32'(quot_ab), 32'(e.quot));
        check({tag, "_rem"},  32'(rem_ab),  32'(e.rem));
        check({tag, "_div0"}, 32'(div0),    32'(e.dz));
    endtask

    // Called at a negedge with the DUT idle; returns #1 after the accept edge
    task automatic send(input string tag, input int av, input int bv);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = A_W'(av);
        b        = B_W'(bv);
        sb.push_back(model(av, bv));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = A_W'($urandom);
        b        = B_W'($urandom);
    endtask

    task automatic wait_result(input string tag);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = out_valid;
        end
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        if (seen) begin
            check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                last_exp = sb.pop_front();
                check_results(tag, last_exp);
            end
        end
    endtask

    task automatic finish_idle(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        int spurious;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_results("rst", '0);
        rst_n = 1'b1;
        @(negedge clk);

        send("t1", 200, 7);
        wait_result("t1");
        finish_idle("t1");

        send("t2", 5, 9);
        wait_result("t2");
        finish_idle("t2");

        send("t3", 77, 0);
        wait_result("t3");
        finish_idle("t3");

        send("t4", 255, 31);
        wait_result("t4");
        finish_idle("t4");
        send("t5", 0, 1);
        wait_result("t5");
        finish_idle("t5");

        // Consumer stalls for 10 cycles while a new request is presented
        out_ready = 1'b0;
        send("hold", 13, 4);
        wait_result("hold");
        in_valid = 1'b1;
        a        = 8'd99;
        b        = 5'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready",  32'(in_ready),  32'd0);
            check("hold_sum",       32'(sum_ab),    32'(last_exp.sum));
            check("hold_quot",      32'(quot_ab),   32'(last_exp.quot));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_idle("hold");
        repeat (3) @(negedge clk);
        check("hold_no_accept", 32'(in_ready), 32'd1);

        // Reset in the middle of the divide aborts the operation
        in_valid = 1'b1;
        a        = 8'd200;
        b        = 5'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check_results("abort", '0);
        @(negedge clk);
        rst_n    = 1'b1;
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("abort_no_out_valid", 32'(spurious), 32'd0);

        send("t6", 31, 2);
        wait_result("t6");
        finish_idle("t6");

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
